// File: rtl/mem_bridge_pkg.sv
// Shared types for the CPU-to-SRAM wait-state bridge.
package mem_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACCESS,
    CAPTURE,
    RESP
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

endpackage

// File: rtl/mem_wait_bridge.sv
// Bridges the CPU read/write/resp handshake onto a 1-cycle-latency single-port SRAM,
// inserting WAIT_CYCLES idle cycles before each access and flagging illegal requests.
module mem_wait_bridge
  import mem_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [3:0]            mem_byte_enable,
  input  logic [31:0]           mem_address,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_resp,
  output logic [31:0]           mem_rdata,
  output logic                  mem_err,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic [3:0]            sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata
);

  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  op_t                     op_q, op_d;
  logic                    oor_q, oor_d;
  logic                    err_q, err_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [3:0]              be_q, be_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;

  logic                    req;
  logic                    req_oor;
  logic                    addr_lsb_unused;

  assign req             = mem_read | mem_write;
  assign req_oor         = |mem_address[31:ADDR_WIDTH+2];
  assign addr_lsb_unused = ^mem_address[1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    oor_d      = oor_q;
    err_d      = err_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    mem_resp   = 1'b0;
    mem_rdata  = '0;
    mem_err    = 1'b0;
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_wdata = '0;

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = mem_address[ADDR_WIDTH+1:2];
          be_d    = mem_byte_enable;
          wdata_d = mem_wdata;
          op_d    = mem_write ? OP_WR : OP_RD;
          oor_d   = req_oor;
          err_d   = req_oor | (mem_read & mem_write);
          // Cleared here so a write or out-of-range response returns zero data.
          rdata_d = '0;
          cnt_d   = '0;
          state_d = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ACCESS: begin
        // Out-of-range requests still walk through ACCESS to keep timing identical.
        if (!oor_q) begin
          sram_cs   = 1'b1;
          sram_addr = addr_q;
          if (op_q == OP_WR) begin
            sram_we    = 1'b1;
            sram_wmask = be_q;
            sram_wdata = wdata_q;
          end
        end
        state_d = (op_q == OP_WR) ? RESP : CAPTURE;
      end
      CAPTURE: begin
        if (!oor_q) rdata_d = sram_rdata;
        state_d = RESP;
      end
      RESP: begin
        mem_resp  = 1'b1;
        mem_rdata = rdata_q;
        mem_err   = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_RD;
      oor_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      oor_q   <= oor_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_wait_bridge.sv
// Directed bench: a W=2 bridge with a byte-masked SRAM model, and a W=0 bridge on a ROM model.
module tb_mem_wait_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_rd, a_wr, a_resp, a_err, a_cs, a_we;
  logic [3:0]  a_be, a_wmask;
  logic [31:0] a_addr, a_wdata, a_rdata, a_swdata, a_srdata;
  logic [13:0] a_saddr;

  logic        b_rd, b_wr, b_resp, b_err, b_cs, b_we;
  logic [3:0]  b_be, b_wmask;
  logic [31:0] b_addr, b_wdata, b_rdata, b_swdata, b_srdata;
  logic [13:0] b_saddr;

  logic [31:0] mem_a [0:16383];

  mem_wait_bridge #(.ADDR_WIDTH(14), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .mem_read(a_rd), .mem_write(a_wr),
    .mem_byte_enable(a_be), .mem_address(a_addr), .mem_wdata(a_wdata),
    .mem_resp(a_resp), .mem_rdata(a_rdata), .mem_err(a_err),
    .sram_cs(a_cs), .sram_we(a_we), .sram_wmask(a_wmask), .sram_addr(a_saddr),
    .sram_wdata(a_swdata), .sram_rdata(a_srdata)
  );

  mem_wait_bridge #(.ADDR_WIDTH(14), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .mem_read(b_rd), .mem_write(b_wr),
    .mem_byte_enable(b_be), .mem_address(b_addr), .mem_wdata(b_wdata),
    .mem_resp(b_resp), .mem_rdata(b_rdata), .mem_err(b_err),
    .sram_cs(b_cs), .sram_we(b_we), .sram_wmask(b_wmask), .sram_addr(b_saddr),
    .sram_wdata(b_swdata), .sram_rdata(b_srdata)
  );

  always @(posedge clk) begin
    if (a_cs) begin
      if (a_we) begin
        for (int i = 0; i < 4; i++)
          if (a_wmask[i]) mem_a[a_saddr][8*i +: 8] <= a_swdata[8*i +: 8];
      end else begin
        a_srdata <= mem_a[a_saddr];
      end
    end
  end

  always @(posedge clk) if (b_cs && !b_we) b_srdata <= {16'hB0B0, 2'b00, b_saddr};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          resp_cyc;
    logic        cs;
    logic [13:0] saddr;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int rc, input logic cs, input logic [13:0] sa,
                              input logic [31:0] rdata, input logic err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.be = be; v.addr = addr; v.wdata = wdata;
    v.resp_cyc = rc; v.cs = cs; v.saddr = sa; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  // Runs one transaction on dut_a; cycle 0 is the cycle whose closing edge samples the request.
  task automatic run_a(input vec_t v, input string tag);
    int resp_cyc = -1, cs_cnt = 0, cs_cyc = -1, leak = 0;
    logic we = 1'b0, err = 1'b0, resp_after;
    logic [3:0] wmask = '0;
    logic [13:0] saddr = '0;
    logic [31:0] swdata = '0, rdata = '0;
    @(negedge clk);
    a_rd = v.rd; a_wr = v.wr; a_be = v.be; a_addr = v.addr; a_wdata = v.wdata;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (a_cs) begin
        cs_cnt++; cs_cyc = k; we = a_we; wmask = a_wmask; saddr = a_saddr; swdata = a_swdata;
      end
      if (!a_resp && a_rdata !== 32'h0) leak++;
      if (a_resp) begin
        resp_cyc = k; rdata = a_rdata; err = a_err;
        break;
      end
    end
    a_rd = 1'b0; a_wr = 1'b0;
    @(negedge clk);
    resp_after = a_resp;
    check({tag, " resp_cycle"}, resp_cyc, v.resp_cyc);
    check({tag, " cs_count"}, cs_cnt, v.cs ? 1 : 0);
    check({tag, " err"}, {31'b0, err}, {31'b0, v.err});
    check({tag, " rdata_idle_zero"}, leak, 0);
    check({tag, " resp_one_cycle"}, {31'b0, resp_after}, 32'h0);
    if (v.cs) begin
      check({tag, " cs_cycle"}, cs_cyc, 3);
      check({tag, " sram_addr"}, {18'b0, saddr}, {18'b0, v.saddr});
      check({tag, " sram_we"}, {31'b0, we}, {31'b0, v.wr});
      if (v.wr) begin
        check({tag, " sram_wmask"}, {28'b0, wmask}, {28'b0, v.be});
        check({tag, " sram_wdata"}, swdata, v.wdata);
      end
    end
    if (v.rd && !v.wr) check({tag, " rdata"}, rdata, v.rdata);
  endtask

  vec_t vecs[16];
  int   cnt_cs, cnt_resp;
  int   b_resp_cyc[3];
  logic [31:0] b_resp_data[3];
  logic b_any_err;

  initial begin
    vecs[0]  = mk(0, 1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 4, 1, 14'd4,      32'h0,         0);
    vecs[1]  = mk(1, 0, 4'h0, 32'h0000_0010, 32'h0,         5, 1, 14'd4,      32'hDEAD_BEEF, 0);
    vecs[2]  = mk(0, 1, 4'hF, 32'h0000_0020, 32'hAABB_CCDD, 4, 1, 14'd8,      32'h0,         0);
    vecs[3]  = mk(0, 1, 4'h5, 32'h0000_0020, 32'h1122_3344, 4, 1, 14'd8,      32'h0,         0);
    vecs[4]  = mk(1, 0, 4'h0, 32'h0000_0020, 32'h0,         5, 1, 14'd8,      32'hAA22_CC44, 0);
    vecs[5]  = mk(1, 0, 4'h0, 32'h0001_0000, 32'h0,         5, 0, 14'd0,      32'h0,         1);
    vecs[6]  = mk(0, 1, 4'hF, 32'h0000_0030, 32'h1234_5678, 4, 1, 14'd12,     32'h0,         0);
    vecs[7]  = mk(0, 1, 4'h0, 32'h0000_0030, 32'hFFFF_FFFF, 4, 1, 14'd12,     32'h0,         0);
    vecs[8]  = mk(1, 0, 4'h0, 32'h0000_0030, 32'h0,         5, 1, 14'd12,     32'h1234_5678, 0);
    vecs[9]  = mk(1, 1, 4'hF, 32'h0000_0040, 32'hA5A5_A5A5, 4, 1, 14'd16,     32'h0,         1);
    vecs[10] = mk(1, 0, 4'h0, 32'h0000_0040, 32'h0,         5, 1, 14'd16,     32'hA5A5_A5A5, 0);
    vecs[11] = mk(0, 1, 4'hF, 32'h8000_0000, 32'h5555_5555, 4, 0, 14'd0,      32'h0,         1);
    vecs[12] = mk(0, 1, 4'hF, 32'h0000_FFFC, 32'hCAFE_F00D, 4, 1, 14'h3FFF,   32'h0,         0);
    vecs[13] = mk(1, 0, 4'h0, 32'h0000_FFFC, 32'h0,         5, 1, 14'h3FFF,   32'hCAFE_F00D, 0);
    vecs[14] = mk(1, 0, 4'h0, 32'h0000_FFFF, 32'h0,         5, 1, 14'h3FFF,   32'hCAFE_F00D, 0);
    vecs[15] = mk(0, 1, 4'hF, 32'h0000_0050, 32'h0BAD_F00D, 4, 1, 14'd20,     32'h0,         0);

    rst_n = 1'b0;
    a_rd = 0; a_wr = 0; a_be = '0; a_addr = '0; a_wdata = '0;
    b_rd = 0; b_wr = 0; b_be = '0; b_addr = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset a_resp", {31'b0, a_resp}, 32'h0);
    check("reset a_err", {31'b0, a_err}, 32'h0);
    check("reset a_cs_we", {30'b0, a_cs, a_we}, 32'h0);
    check("reset a_rdata", a_rdata, 32'h0);
    check("reset a_sram_bus", {a_wmask, a_saddr} | a_swdata, 32'h0);
    check("reset b_resp_cs", {30'b0, b_resp, b_cs}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run_a(vecs[i], $sformatf("v%0d", i));

    // Reset during WAIT of a write to word 20: aborted, no cs, no resp.
    @(negedge clk);
    a_wr = 1'b1; a_be = 4'hF; a_addr = 32'h0000_0050; a_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; a_wr = 1'b0;
    cnt_cs = 0; cnt_resp = 0;
    for (int k = 0; k < 8; k++) begin
      if (a_cs) cnt_cs++;
      if (a_resp) cnt_resp++;
      @(negedge clk);
    end
    check("abort cs_count", cnt_cs, 0);
    check("abort resp_count", cnt_resp, 0);
    run_a(mk(1, 0, 4'h0, 32'h0000_0050, 32'h0, 5, 1, 14'd20, 32'h0BAD_F00D, 0), "after_abort");

    // W=0, read held high; address changes mid-transaction must not affect the latched request.
    b_resp_cyc = '{-1, -1, -1};
    b_resp_data = '{32'h0, 32'h0, 32'h0};
    cnt_cs = 0; cnt_resp = 0; b_any_err = 1'b0;
    @(negedge clk);
    b_rd = 1'b1; b_addr = 32'h0000_0044;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 2) b_addr = 32'h0000_0048;
      if (b_cs) cnt_cs++;
      if (b_resp) begin
        if (cnt_resp < 3) begin
          b_resp_cyc[cnt_resp] = k;
          b_resp_data[cnt_resp] = b_rdata;
        end
        cnt_resp++;
        b_any_err |= b_err;
      end
    end
    b_rd = 1'b0;
    check("b2b resp_count", cnt_resp, 3);
    check("b2b cs_count", cnt_cs, 3);
    check("b2b resp0_cycle", b_resp_cyc[0], 3);
    check("b2b resp1_cycle", b_resp_cyc[1], 7);
    check("b2b resp2_cycle", b_resp_cyc[2], 11);
    check("b2b rdata0", b_resp_data[0], 32'hB0B0_0011);
    check("b2b rdata1", b_resp_data[1], 32'hB0B0_0012);
    check("b2b rdata2", b_resp_data[2], 32'hB0B0_0012);
    check("b2b err", {31'b0, b_any_err}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
